// File: rtl/conv_encoder_sys.sv
`default_nettype none
// ============================================================================
// Module      : conv_encoder_sys
// Description : Rate-1/2 convolutional encoder, K selectable 3..6. Serialises
//               a FRAME_LEN-bit word MSB first, one 2-bit symbol per bit,
//               under a valid/ready handshake. Optional zero tail.
// Options     : TAIL_FLUSH_EN - when defined, K-1 zero-input tail symbols
//               terminate each frame so the trellis ends in state 0.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_encoder_sys #(
  parameter int FRAME_LEN = 16,
  parameter int MAX_K     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           choose_constraint_length,
  input  logic [FRAME_LEN-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [1:0]           encoded_bits,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(FRAME_LEN + MAX_K);
  localparam logic [CNT_W-1:0] c_frame_len = CNT_W'(FRAME_LEN);

`ifdef TAIL_FLUSH_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ENCODE = 2'd1, ST_FLUSH = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ENCODE = 2'd1} state_t;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FRAME_LEN-1:0] r_data;      // remaining payload, next bit at MSB
  logic [MAX_K-2:0]     r_sr;        // past inputs, most recent at MSB
  logic [2:0]           r_k;
  logic [CNT_W-1:0]     r_cnt;       // symbols emitted so far this frame
  logic [1:0]           r_sym;
  logic                 r_sym_valid;
  logic                 r_frame_done;

  logic                 w_xfer;
  logic                 w_load;
  logic                 w_emit;
  logic                 w_last;
  logic                 w_u;
  logic [2:0]           w_k_in;
  logic [2:0]           w_k_sel;
  logic [MAX_K-2:0]     w_sr_src;
  logic [MAX_K-1:0]     w_win;
  logic [MAX_K-1:0]     w_g0_raw;
  logic [MAX_K-1:0]     w_g1_raw;
  logic [MAX_K-1:0]     w_g0;
  logic [MAX_K-1:0]     w_g1;
  logic [2:0]           w_shift;
  logic [1:0]           w_sym;
`ifdef TAIL_FLUSH_EN
  logic [CNT_W-1:0]     w_total;
  assign w_total = c_frame_len + CNT_W'(r_k) - CNT_W'(1);
`endif

  assign w_xfer  = r_sym_valid & sym_ready;
  // Out-of-range selections fall back to K=3
  assign w_k_in  = (choose_constraint_length >= 3'd3 && choose_constraint_length <= 3'd6)
                   ? choose_constraint_length : 3'd3;
  // A load encodes its first bit from the freshly latched K and a cleared register
  assign w_k_sel  = w_load ? w_k_in : r_k;
  assign w_sr_src = w_load ? '0 : r_sr;
  assign w_win    = {w_u, w_sr_src};

  // Polynomials are left-aligned to MAX_K bits so the MSB always taps the
  // current input and taps beyond K-1 bits of history fall on zeros
  always_comb begin
    w_g0_raw = MAX_K'('o7);
    w_g1_raw = MAX_K'('o5);
    case (w_k_sel)
      3'd4:    begin w_g0_raw = MAX_K'('o15); w_g1_raw = MAX_K'('o17); end
      3'd5:    begin w_g0_raw = MAX_K'('o23); w_g1_raw = MAX_K'('o35); end
      3'd6:    begin w_g0_raw = MAX_K'('o53); w_g1_raw = MAX_K'('o75); end
      default: begin w_g0_raw = MAX_K'('o7);  w_g1_raw = MAX_K'('o5);  end
    endcase
  end

  assign w_shift = 3'(MAX_K) - w_k_sel;
  assign w_g0    = w_g0_raw << w_shift;
  assign w_g1    = w_g1_raw << w_shift;
  assign w_sym   = {^(w_g0 & w_win), ^(w_g1 & w_win)};

  // Next-state and symbol-emission control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_emit      = 1'b0;
    w_last      = 1'b0;
    w_u         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_valid) begin
          w_load      = 1'b1;
          w_emit      = 1'b1;
          w_u         = data_in[FRAME_LEN-1];
          w_state_nxt = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        if (w_xfer) begin
          if (r_cnt == c_frame_len) begin
`ifdef TAIL_FLUSH_EN
            w_emit      = 1'b1;
            w_state_nxt = ST_FLUSH;
`else
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
`endif
          end else begin
            w_emit = 1'b1;
            w_u    = r_data[FRAME_LEN-1];
          end
        end
      end
`ifdef TAIL_FLUSH_EN
      ST_FLUSH: begin
        if (w_xfer) begin
          if (r_cnt == w_total) begin
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_emit = 1'b1;
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered symbol outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_data       <= '0;
      r_sr         <= '0;
      r_k          <= 3'd3;
      r_cnt        <= '0;
      r_sym        <= 2'b00;
      r_sym_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_last;
      if (w_load) begin
        r_data <= data_in << 1;
        r_k    <= w_k_in;
      end else if (w_emit) begin
        r_data <= r_data << 1;
      end
      if (w_emit) begin
        r_sym       <= w_sym;
        r_sym_valid <= 1'b1;
        r_sr        <= {w_u, w_sr_src[MAX_K-2:1]};
        r_cnt       <= w_load ? CNT_W'(1) : r_cnt + CNT_W'(1);
      end else if (w_last) begin
        r_sym_valid <= 1'b0;
      end
    end
  end

  assign data_ready   = (r_state == ST_IDLE);
  assign encoded_bits = r_sym;
  assign sym_valid    = r_sym_valid;
  assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_sys.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_encoder_sys
// Description : Self-checking bench for conv_encoder_sys (scoreboard queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_encoder_sys;

`ifdef TAIL_FLUSH_EN
  localparam int TAIL = 1;
`else
  localparam int TAIL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  choose_constraint_length;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [1:0]  encoded_bits;
  logic        sym_valid;
  logic        sym_ready;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  q[$];

  conv_encoder_sys #(.FRAME_LEN(16), .MAX_K(6)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .choose_constraint_length (choose_constraint_length),
    .data_in                  (data_in),
    .data_valid               (data_valid),
    .data_ready               (data_ready),
    .encoded_bits             (encoded_bits),
    .sym_valid                (sym_valid),
    .sym_ready                (sym_ready),
    .frame_done               (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: K-bit window with the current bit at the MSB
  function automatic void push_model(input int k, input logic [15:0] d);
    int         keff;
    int         nsym;
    logic [5:0] g0;
    logic [5:0] g1;
    logic [5:0] win;
    logic       u;
    keff = (k >= 3 && k <= 6) ? k : 3;
    case (keff)
      4:       begin g0 = 6'o15; g1 = 6'o17; end
      5:       begin g0 = 6'o23; g1 = 6'o35; end
      6:       begin g0 = 6'o53; g1 = 6'o75; end
      default: begin g0 = 6'o07; g1 = 6'o05; end
    endcase
    nsym = 16 + TAIL * (keff - 1);
    win  = '0;
    for (int i = 0; i < nsym; i++) begin
      u   = (i < 16) ? d[15-i] : 1'b0;
      win = (win >> 1) | (6'(u) << (keff - 1));
      q.push_back({^(g0 & win), ^(g1 & win)});
    end
  endfunction

  // Literal expectation for K=3, data 16'h8000: 11,10,11 then zeros
  function automatic void push_k3_impulse();
    q.push_back(2'b11);
    q.push_back(2'b10);
    q.push_back(2'b11);
    for (int i = 3; i < 16 + 2 * TAIL; i++) q.push_back(2'b00);
  endfunction

  // Called at a negedge with the encoder idle; consumes the queue
  task automatic run_frame(input logic [2:0] k, input logic [15:0] d, input bit bp,
                           input int abort_at);
    int         n;
    int         budget;
    bit         stalled;
    logic [1:0] held;
    logic [1:0] exp;
    n       = 0;
    budget  = 0;
    stalled = 1'b0;
    held    = 2'b00;
    check("ready_before_load", 16'(data_ready), 16'd1);
    choose_constraint_length = k;
    data_in    = d;
    data_valid = 1'b1;
    sym_ready  = 1'b1;
    @(posedge clk);
    #1;
    choose_constraint_length = 3'($urandom_range(0, 7));
    data_in = 16'($urandom);
    @(negedge clk);
    check("first_sym_latency", 16'(sym_valid), 16'd1);
    while (q.size() > 0) begin
      if (abort_at != 0 && n == abort_at - 1) begin
        rst        = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        check("abort_sym_valid", 16'(sym_valid), 16'd0);
        check("abort_data_ready", 16'(data_ready), 16'd1);
        check("abort_frame_done", 16'(frame_done), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done", 16'(frame_done), 16'd0);
        q.delete();
        return;
      end
      sym_ready  = bp ? ~sym_ready : 1'b1;
      data_valid = 1'($urandom_range(0, 1));
      check("busy_data_ready", 16'(data_ready), 16'd0);
      check("busy_frame_done", 16'(frame_done), 16'd0);
      check("busy_sym_valid", 16'(sym_valid), 16'd1);
      if (stalled) check("stall_hold", 16'(encoded_bits), 16'(held));
      if (sym_ready) begin
        exp = q.pop_front();
        check($sformatf("sym%0d", n), 16'(encoded_bits), 16'(exp));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = encoded_bits;
      end
      if (q.size() == 0) data_valid = 1'b0;
      @(negedge clk);
      budget++;
      if (budget > 100) begin
        checks++;
        errors++;
        $error("FAIL timeout: observed %0d symbols, %0d still expected", n, q.size());
        q.delete();
      end
    end
    check("end_sym_valid", 16'(sym_valid), 16'd0);
    check("end_frame_done", 16'(frame_done), 16'd1);
    check("end_data_ready", 16'(data_ready), 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    choose_constraint_length = 3'd3;
    data_in    = '0;
    data_valid = 1'b0;
    sym_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_ready", 16'(data_ready), 16'd1);
    check("rst_sym_valid", 16'(sym_valid), 16'd0);
    check("rst_encoded_bits", 16'(encoded_bits), 16'd0);
    check("rst_frame_done", 16'(frame_done), 16'd0);
    rst = 1'b0;

    push_k3_impulse();           run_frame(3'd3, 16'h8000, 1'b0, 0);
    push_model(3, 16'hFFFF);     run_frame(3'd3, 16'hFFFF, 1'b0, 0);
    push_model(6, 16'h8000);     run_frame(3'd6, 16'h8000, 1'b0, 0);
    push_model(7, 16'h8000);     run_frame(3'd7, 16'h8000, 1'b0, 0);
    push_model(4, 16'h8000);     run_frame(3'd4, 16'h8000, 1'b0, 0);
    push_model(5, 16'h3C96);     run_frame(3'd5, 16'h3C96, 1'b0, 0);
    push_model(0, 16'h1234);     run_frame(3'd0, 16'h1234, 1'b0, 0);
    push_model(3, 16'hA5A5);     run_frame(3'd3, 16'hA5A5, 1'b1, 0);
    push_model(6, 16'hC3E1);     run_frame(3'd6, 16'hC3E1, 1'b1, 0);
    push_model(3, 16'h8000);     run_frame(3'd3, 16'h8000, 1'b0, 5);
    push_k3_impulse();           run_frame(3'd3, 16'h8000, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("idle_frame_done", 16'(frame_done), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
